// File: rtl/maquina_param.sv
// maquina_param: FIFO bank monitor with per-channel occupancy and threshold flags.
// Build option: MAQUINA_PARAM_ERROR_RECOVERY_EN lets init=1 leave ERROR.
module maquina_param #(
  parameter int NUM_FIFOS = 4,
  parameter int DEPTH     = 8,
  parameter int UMBRAL_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [UMBRAL_W-1:0]  umbral_alto_in,
  input  logic [UMBRAL_W-1:0]  umbral_bajo_in,
  input  logic [NUM_FIFOS-1:0] fifo_full,
  input  logic [NUM_FIFOS-1:0] fifo_empty,
  input  logic [NUM_FIFOS-1:0] fifo_read,
  input  logic [NUM_FIFOS-1:0] fifo_write,
  output logic                 init_out,
  output logic                 idle_out,
  output logic                 active_out,
  output logic                 error_out,
  output logic [UMBRAL_W-1:0]  umbral_alto_out,
  output logic [UMBRAL_W-1:0]  umbral_bajo_out,
  output logic [NUM_FIFOS-1:0] almost_full,
  output logic [NUM_FIFOS-1:0] almost_empty,
  output logic [NUM_FIFOS-1:0] error_fifo
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int MW = (CW > UMBRAL_W) ? CW : UMBRAL_W;
  localparam logic [UMBRAL_W-1:0] ALTO_DEF = UMBRAL_W'(DEPTH - 1);
  localparam logic [UMBRAL_W-1:0] BAJO_DEF = UMBRAL_W'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_RESET,
    S_INIT,
    S_IDLE,
    S_ACTIVE,
    S_ERROR
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0] cnt    [NUM_FIFOS];
  logic [CW-1:0] cnt_nx [NUM_FIFOS];

  logic [NUM_FIFOS-1:0] evt;
  logic [NUM_FIFOS-1:0] err_nx;
  logic [NUM_FIFOS-1:0] af_nx;
  logic [NUM_FIFOS-1:0] ae_nx;
  logic [UMBRAL_W-1:0]  alto_nx;
  logic [UMBRAL_W-1:0]  bajo_nx;
  logic                 running;
  logic                 any_evt;
  logic                 recover;

  assign evt = (fifo_write & fifo_full & ~fifo_read)
             | (fifo_read & fifo_empty);
  assign running = (state != S_RESET);
  assign any_evt = running & (|evt);

  // Error beats init, init beats the empty/non-empty moves.
  always_comb begin
    state_nx = state;
    recover  = 1'b0;
    unique case (state)
      S_RESET: state_nx = S_INIT;
      S_INIT: begin
        if (any_evt)    state_nx = S_ERROR;
        else if (!init) state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (any_evt)             state_nx = S_ERROR;
        else if (init)           state_nx = S_INIT;
        else if (!(&fifo_empty)) state_nx = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (any_evt)          state_nx = S_ERROR;
        else if (init)        state_nx = S_INIT;
        else if (&fifo_empty) state_nx = S_IDLE;
      end
      S_ERROR: begin
`ifdef MAQUINA_PARAM_ERROR_RECOVERY_EN
        if (!any_evt && init) begin
          state_nx = S_INIT;
          recover  = 1'b1;
        end
`else
        state_nx = S_ERROR;
`endif
      end
      default: state_nx = S_RESET;
    endcase
  end

  always_comb begin
    alto_nx = umbral_alto_out;
    bajo_nx = umbral_bajo_out;
    if (state == S_INIT) begin
      if (state_nx != S_INIT &&
          umbral_bajo_in > umbral_alto_in) begin
        alto_nx = ALTO_DEF;
        bajo_nx = BAJO_DEF;
      end else begin
        alto_nx = umbral_alto_in;
        bajo_nx = umbral_bajo_in;
      end
    end
  end

  always_comb begin
    err_nx = error_fifo;
    if (recover)      err_nx = '0;
    else if (running) err_nx = error_fifo | evt;
  end

  // Flags are taken from the post-update count and thresholds.
  always_comb begin
    for (int i = 0; i < NUM_FIFOS; i++) begin
      cnt_nx[i] = cnt[i];
      if (running) begin
        if (fifo_write[i] && !fifo_read[i] &&
            cnt[i] != CNT_MAX)
          cnt_nx[i] = cnt[i] + CW'(1);
        else if (fifo_read[i] && !fifo_write[i] &&
                 cnt[i] != '0)
          cnt_nx[i] = cnt[i] - CW'(1);
      end
      af_nx[i] = MW'(cnt_nx[i]) >= MW'(alto_nx);
      ae_nx[i] = MW'(cnt_nx[i]) <= MW'(bajo_nx);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_RESET;
      init_out        <= 1'b0;
      idle_out        <= 1'b0;
      active_out      <= 1'b0;
      error_out       <= 1'b0;
      umbral_alto_out <= ALTO_DEF;
      umbral_bajo_out <= BAJO_DEF;
      almost_full     <= '0;
      almost_empty    <= '1;
      error_fifo      <= '0;
      for (int i = 0; i < NUM_FIFOS; i++)
        cnt[i] <= '0;
    end else begin
      state           <= state_nx;
      init_out        <= (state_nx == S_INIT);
      idle_out        <= (state_nx == S_IDLE);
      active_out      <= (state_nx == S_ACTIVE);
      error_out       <= (state_nx == S_ERROR);
      umbral_alto_out <= alto_nx;
      umbral_bajo_out <= bajo_nx;
      almost_full     <= af_nx;
      almost_empty    <= ae_nx;
      error_fifo      <= err_nx;
      for (int i = 0; i < NUM_FIFOS; i++)
        cnt[i] <= cnt_nx[i];
    end
  end

endmodule

// File: tb/tb_maquina_param.sv
// tb_maquina_param: directed and randomized checks of maquina_param
// against a behavioural model of channel occupancy and monitor state.
module tb_maquina_param;

  localparam int NF = 4;
  localparam int D  = 8;
  localparam int UW = 4;

  localparam int M_RST = 0;
  localparam int M_INI = 1;
  localparam int M_IDL = 2;
  localparam int M_ACT = 3;
  localparam int M_ERR = 4;

  logic          clk;
  logic          reset;
  logic          init;
  logic [UW-1:0] alto_in, bajo_in;
  logic [NF-1:0] full, empty, rd, wr;
  logic          init_out, idle_out, active_out, error_out;
  logic [UW-1:0] alto_out, bajo_out;
  logic [NF-1:0] af, ae, ef;

  maquina_param #(.NUM_FIFOS(NF), .DEPTH(D), .UMBRAL_W(UW)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_alto_in(alto_in), .umbral_bajo_in(bajo_in),
    .fifo_full(full), .fifo_empty(empty),
    .fifo_read(rd), .fifo_write(wr),
    .init_out(init_out), .idle_out(idle_out),
    .active_out(active_out), .error_out(error_out),
    .umbral_alto_out(alto_out), .umbral_bajo_out(bajo_out),
    .almost_full(af), .almost_empty(ae), .error_fifo(ef)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  int mst;
  int mcnt [NF];
  int malto, mbajo;
  logic [NF-1:0] mef, maf, mae;

  task automatic model_reset();
    mst = M_RST;
    for (int i = 0; i < NF; i++) mcnt[i] = 0;
    malto = D - 1;
    mbajo = 1;
    mef = '0;
    maf = '0;
    mae = '1;
  endtask

  task automatic model_step();
    int nst;
    logic [NF-1:0] ev;
    bit anyev;
    if (mst == M_RST) begin
      mst = M_INI;
      return;
    end
    for (int i = 0; i < NF; i++) begin
      ev[i] = (wr[i] & full[i] & ~rd[i]) | (rd[i] & empty[i]);
      if (wr[i] && !rd[i] && mcnt[i] < D) mcnt[i]++;
      if (rd[i] && !wr[i] && mcnt[i] > 0) mcnt[i]--;
    end
    anyev = (ev != '0);
    nst = mst;
    if (mst == M_ERR) begin
`ifdef MAQUINA_PARAM_ERROR_RECOVERY_EN
      if (!anyev && init) nst = M_INI;
`endif
    end else if (anyev) nst = M_ERR;
    else if (mst == M_INI) nst = init ? M_INI : M_IDL;
    else if (init) nst = M_INI;
    else if (mst == M_IDL && empty != '1) nst = M_ACT;
    else if (mst == M_ACT && empty == '1) nst = M_IDL;
    if (mst == M_ERR && nst == M_INI) mef = '0;
    else mef = mef | ev;
    if (mst == M_INI) begin
      malto = int'(alto_in);
      mbajo = int'(bajo_in);
      if (nst != M_INI && bajo_in > alto_in) begin
        malto = D - 1;
        mbajo = 1;
      end
    end
    mst = nst;
    for (int i = 0; i < NF; i++) begin
      maf[i] = (mcnt[i] >= malto);
      mae[i] = (mcnt[i] <= mbajo);
    end
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(posedge clk) begin
    #1;
    chk("state_ind", 32'({init_out, idle_out, active_out, error_out}),
        32'({mst == M_INI, mst == M_IDL, mst == M_ACT, mst == M_ERR}));
    chk("umbral_alto", 32'(alto_out), 32'(malto));
    chk("umbral_bajo", 32'(bajo_out), 32'(mbajo));
    chk("almost_full", 32'(af), 32'(maf));
    chk("almost_empty", 32'(ae), 32'(mae));
    chk("error_fifo", 32'(ef), 32'(mef));
  end

  task automatic drive_idle();
    init  = 1'b0;
    wr    = '0;
    rd    = '0;
    full  = '0;
    empty = '1;
  endtask

  task automatic do_reset(int a, int b);
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
    alto_in = UW'(a);
    bajo_in = UW'(b);
    init    = 1'b1;
    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    alto_in = 4'd7;
    bajo_in = 4'd1;
    drive_idle();
    #2 reset = 1'b0;
    #1;
    chk("rst_ind", 32'({init_out, idle_out, active_out, error_out}), 32'd0);
    chk("rst_flags", 32'({af, ae}), 32'h0f);
    repeat (2) @(negedge clk);

    alto_in = 4'd6;
    bajo_in = 4'd2;
    init    = 1'b1;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    chk("init_held", 32'(init_out), 32'd1);
    init = 1'b0;
    @(negedge clk);
    chk("idle_after_init", 32'({idle_out, init_out}), 32'd2);
    chk("alto_6", 32'(alto_out), 32'd6);
    chk("bajo_2", 32'(bajo_out), 32'd2);

    do_reset(7, 1);
    empty[0] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      wr[0] = 1'b1;
      @(negedge clk);
      chk("af0_after_write", 32'(af[0]), 32'(k == 6));
      chk("active_writes", 32'(active_out), 32'd1);
    end
    wr[0] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      rd[0] = 1'b1;
      @(negedge clk);
      chk("active_reads", 32'(active_out), 32'd1);
    end
    rd[0] = 1'b0;
    empty[0] = 1'b1;
    @(negedge clk);
    chk("idle_after_drain", 32'(idle_out), 32'd1);
    chk("ae0_drained", 32'(ae[0]), 32'd1);

    empty[1] = 1'b0;
    wr[1] = 1'b1;
    repeat (3) @(negedge clk);
    rd[1] = 1'b1;
    @(negedge clk);
    chk("rw_ch1_flags", 32'({af[1], ae[1]}), 32'd0);
    wr[1] = 1'b0;
    rd[1] = 1'b0;
    rd[3] = 1'b1;
    @(negedge clk);
    rd[3] = 1'b0;
    chk("underflow_ch3", 32'(ef), 32'h8);
    chk("underflow_err", 32'(error_out), 32'd1);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
`ifdef MAQUINA_PARAM_ERROR_RECOVERY_EN
    chk("recover_init", 32'(init_out), 32'd1);
    chk("recover_clear", 32'(ef), 32'd0);
`else
    chk("error_held", 32'(error_out), 32'd1);
    chk("error_kept", 32'(ef), 32'h8);
`endif

    do_reset(7, 1);
    empty[2] = 1'b0;
    full[2]  = 1'b1;
    wr[2]    = 1'b1;
    @(negedge clk);
    chk("overflow_ch2", 32'(ef), 32'h4);
    chk("overflow_err", 32'(error_out), 32'd1);
    full[2] = 1'b0;
    repeat (6) @(negedge clk);
    wr[2] = 1'b0;
    chk("count_in_error", 32'(af[2]), 32'd1);

    do_reset(7, 1);
    empty[0] = 1'b0;
    wr[0] = 1'b1;
    @(negedge clk);
    wr[0] = 1'b0;
    chk("pre_reset_active", 32'(active_out), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_ind", 32'({init_out, idle_out, active_out, error_out}), 32'd0);
    chk("async_flags", 32'({ef, af, ae}), 32'h00f);
    chk("async_umbral", 32'({alto_out, bajo_out}), 32'h71);
    @(negedge clk);

    do_reset(3, 5);
    chk("swap_alto", 32'(alto_out), 32'd7);
    chk("swap_bajo", 32'(bajo_out), 32'd1);

    for (int ep = 0; ep < 6; ep++) begin
      do_reset($urandom_range(0, 15), $urandom_range(0, 15));
      for (int c = 0; c < 150; c++) begin
        for (int i = 0; i < NF; i++) begin
          wr[i]    = ($urandom_range(0, 2) == 0);
          rd[i]    = ($urandom_range(0, 2) == 0);
          empty[i] = (mcnt[i] == 0);
          full[i]  = (mcnt[i] == D);
          if ($urandom_range(0, 39) == 0) empty[i] = ~empty[i];
          if ($urandom_range(0, 39) == 0) full[i] = ~full[i];
        end
        init = ($urandom_range(0, 49) == 0);
        if (init) begin
          alto_in = UW'($urandom_range(0, 15));
          bajo_in = UW'($urandom_range(0, 15));
        end
        @(negedge clk);
      end
    end

    drive_idle();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
